// File: rtl/bp_pkg.sv
// Shared counter encodings and index hash for the gshare branch predictor.
// Optional perf counters are enabled by defining BP_PERF_COUNTERS_EN.
package bp_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam logic [1:0] PHT_INIT = WNT;

  localparam int unsigned BP_PC_W   = 64;
  localparam int unsigned BP_HASH_W = 32;

  // PC word index XOR zero-extended history, masked to the table index width
  function automatic logic [BP_HASH_W-1:0] bp_index(input logic [BP_PC_W-1:0]   pc,
                                                    input logic [BP_HASH_W-1:0] hist,
                                                    input int unsigned          index_width);
    logic [BP_HASH_W-1:0] mask;
    mask = (BP_HASH_W'(1) << index_width) - BP_HASH_W'(1);
    return (BP_HASH_W'(pc >> 2) ^ hist) & mask;
  endfunction

  function automatic logic [1:0] bp_sat_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && (ctr != ST)) begin
      nxt = ctr + 2'd1;
    end else if (!taken && (ctr != SNT)) begin
      nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/gshare_branch_predictor_if.sv
// Fetch/predict and resolve/update bundle for the gshare predictor.
// Perf counter signals exist only when BP_PERF_COUNTERS_EN is defined.
interface gshare_branch_predictor_if #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned HIST_WIDTH  = 5,
  parameter int unsigned FETCH_WIDTH = 2
) ();

  logic [ADDR_WIDTH-1:0]             fetch_pc_i;
  logic                              fetch_valid_i;
  logic [FETCH_WIDTH-1:0]            is_branch_i;
  logic [FETCH_WIDTH-1:0]            pred_taken_o;
  logic [FETCH_WIDTH*HIST_WIDTH-1:0] pred_hist_o;

  logic                              upd_valid_i;
  logic [ADDR_WIDTH-1:0]             upd_pc_i;
  logic [HIST_WIDTH-1:0]             upd_hist_i;
  logic                              upd_taken_i;
  logic                              upd_mispredict_i;

`ifdef BP_PERF_COUNTERS_EN
  logic [31:0]                       perf_branches_o;
  logic [31:0]                       perf_mispredicts_o;

  modport master (
    output fetch_pc_i, fetch_valid_i, is_branch_i,
    output upd_valid_i, upd_pc_i, upd_hist_i, upd_taken_i, upd_mispredict_i,
    input  pred_taken_o, pred_hist_o,
    input  perf_branches_o, perf_mispredicts_o
  );

  modport slave (
    input  fetch_pc_i, fetch_valid_i, is_branch_i,
    input  upd_valid_i, upd_pc_i, upd_hist_i, upd_taken_i, upd_mispredict_i,
    output pred_taken_o, pred_hist_o,
    output perf_branches_o, perf_mispredicts_o
  );
`else
  modport master (
    output fetch_pc_i, fetch_valid_i, is_branch_i,
    output upd_valid_i, upd_pc_i, upd_hist_i, upd_taken_i, upd_mispredict_i,
    input  pred_taken_o, pred_hist_o
  );

  modport slave (
    input  fetch_pc_i, fetch_valid_i, is_branch_i,
    input  upd_valid_i, upd_pc_i, upd_hist_i, upd_taken_i, upd_mispredict_i,
    output pred_taken_o, pred_hist_o
  );
`endif

endinterface

// File: rtl/bp_pht.sv
// Pattern history table: 2-bit saturating counters, multiple combinational
// read ports, one training write port, async active-low reset to weak not-taken.
module bp_pht
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES     = 32,
  parameter int unsigned INDEX_WIDTH = $clog2(ENTRIES),
  parameter int unsigned NUM_READ    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [INDEX_WIDTH-1:0] rd_idx [NUM_READ],
  output logic [1:0]             rd_ctr [NUM_READ],
  input  logic                   wr_en,
  input  logic [INDEX_WIDTH-1:0] wr_idx,
  input  logic                   wr_taken
);

  logic [1:0] ctr_q [ENTRIES];

  // Training write; reads in the same cycle see the pre-edge value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int e = 0; e < int'(ENTRIES); e++) begin
        ctr_q[e] <= PHT_INIT;
      end
    end else if (wr_en) begin
      ctr_q[wr_idx] <= bp_sat_update(ctr_q[wr_idx], wr_taken);
    end
  end

  always_comb begin
    for (int r = 0; r < int'(NUM_READ); r++) begin
      rd_ctr[r] = ctr_q[rd_idx[r]];
    end
  end

endmodule

// File: rtl/gshare_branch_predictor.sv
// Multi-lane gshare direction predictor: speculative GHR, per-lane history chain
// with taken-squash, misprediction recovery; perf counters under BP_PERF_COUNTERS_EN.
module gshare_branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES     = 32,
  parameter int unsigned INDEX_WIDTH = $clog2(ENTRIES),
  parameter int unsigned HIST_WIDTH  = 5,
  parameter int unsigned FETCH_WIDTH = 2,
  parameter int unsigned ADDR_WIDTH  = 32
) (
  input logic                     clk,
  input logic                     reset,
  gshare_branch_predictor_if.slave bus
);

  logic [HIST_WIDTH-1:0]  ghr_q;
  logic [HIST_WIDTH-1:0]  lane_hist [FETCH_WIDTH+1];
  logic [FETCH_WIDTH-1:0] taken_seen;
  logic [FETCH_WIDTH-1:0] pred;
  logic [INDEX_WIDTH-1:0] rd_idx [FETCH_WIDTH];
  logic [1:0]             rd_ctr [FETCH_WIDTH];
  logic [INDEX_WIDTH-1:0] wr_idx;

  assign lane_hist[0]  = ghr_q;
  assign taken_seen[0] = 1'b0;

  // Lane i sees history including predictions of earlier live branch lanes
  for (genvar i = 0; i < int'(FETCH_WIDTH); i++) begin : g_lane
    logic [ADDR_WIDTH-1:0] lane_pc;
    logic                  live;

    assign lane_pc   = bus.fetch_pc_i + ADDR_WIDTH'(4 * i);
    assign rd_idx[i] = INDEX_WIDTH'(bp_index(BP_PC_W'(lane_pc), BP_HASH_W'(lane_hist[i]),
                                             INDEX_WIDTH));
    assign live      = bus.is_branch_i[i] & ~taken_seen[i];
    assign pred[i]   = live & rd_ctr[i][1];

    assign lane_hist[i+1] = live ? {lane_hist[i][HIST_WIDTH-2:0], pred[i]} : lane_hist[i];
    assign bus.pred_hist_o[i*HIST_WIDTH +: HIST_WIDTH] = lane_hist[i];

    if (i < int'(FETCH_WIDTH) - 1) begin : g_seen
      assign taken_seen[i+1] = taken_seen[i] | pred[i];
    end
  end

  assign bus.pred_taken_o = pred;

  assign wr_idx = INDEX_WIDTH'(bp_index(BP_PC_W'(bus.upd_pc_i), BP_HASH_W'(bus.upd_hist_i),
                                        INDEX_WIDTH));

  bp_pht #(
    .ENTRIES     (ENTRIES),
    .INDEX_WIDTH (INDEX_WIDTH),
    .NUM_READ    (FETCH_WIDTH)
  ) u_pht (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (rd_idx),
    .rd_ctr   (rd_ctr),
    .wr_en    (bus.upd_valid_i),
    .wr_idx   (wr_idx),
    .wr_taken (bus.upd_taken_i)
  );

  // Recovery wins over a fetch shift: the fetched bundle is being flushed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ghr_q <= '0;
    end else if (bus.upd_valid_i && bus.upd_mispredict_i) begin
      ghr_q <= {bus.upd_hist_i[HIST_WIDTH-2:0], bus.upd_taken_i};
    end else if (bus.fetch_valid_i) begin
      ghr_q <= lane_hist[FETCH_WIDTH];
    end
  end

`ifdef BP_PERF_COUNTERS_EN
  logic [31:0] perf_branches_q;
  logic [31:0] perf_mispredicts_q;

  // Saturating event counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_branches_q    <= '0;
      perf_mispredicts_q <= '0;
    end else if (bus.upd_valid_i) begin
      if (perf_branches_q != 32'hFFFF_FFFF) begin
        perf_branches_q <= perf_branches_q + 32'd1;
      end
      if (bus.upd_mispredict_i && (perf_mispredicts_q != 32'hFFFF_FFFF)) begin
        perf_mispredicts_q <= perf_mispredicts_q + 32'd1;
      end
    end
  end

  assign bus.perf_branches_o    = perf_branches_q;
  assign bus.perf_mispredicts_o = perf_mispredicts_q;
`endif

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Self-checking bench for gshare_branch_predictor: directed scenarios plus
// randomized traffic against an array-based reference model.
module tb_gshare_branch_predictor;

  localparam int unsigned ENTRIES = 32;
  localparam int unsigned HW      = 5;
  localparam int unsigned FW      = 2;
  localparam int unsigned AW      = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gshare_branch_predictor_if #(.ADDR_WIDTH(AW), .HIST_WIDTH(HW), .FETCH_WIDTH(FW)) bus ();

  gshare_branch_predictor #(
    .ENTRIES(ENTRIES), .HIST_WIDTH(HW), .FETCH_WIDTH(FW), .ADDR_WIDTH(AW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int     m_pht [ENTRIES];
  int     m_ghr;
  longint m_br;
  longint m_mis;
  int     n_checks = 0;
  int     n_fail   = 0;

  logic [1:0] obs_pt;
  logic [9:0] obs_ph;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int e = 0; e < int'(ENTRIES); e++) m_pht[e] = 1;
    m_ghr = 0;
    m_br  = 0;
    m_mis = 0;
  endfunction

  // Walk lanes in order; after the first taken prediction later lanes are dead
  function automatic void model_predict(input logic [31:0] pc, input logic [1:0] br,
                                        output logic [1:0] pt, output logic [9:0] ph,
                                        output int ghr_after);
    int h;
    bit seen;
    h = m_ghr;
    seen = 0;
    pt = '0;
    ph = '0;
    for (int i = 0; i < int'(FW); i++) begin
      logic [31:0] lpc;
      int idx;
      bit p;
      lpc = pc + 32'(4 * i);
      ph[i*5 +: 5] = 5'(h);
      idx = int'(((lpc >> 2) ^ 32'(h)) % 32'(ENTRIES));
      p = br[i] && !seen && (m_pht[idx] >= 2);
      pt[i] = p;
      if (br[i] && !seen) h = ((h * 2) + int'(p)) % 32;
      if (p) seen = 1;
    end
    ghr_after = h;
  endfunction

  task automatic drive(input logic [31:0] pc, input bit fv, input logic [1:0] br,
                       input bit uv, input logic [31:0] upc, input logic [4:0] uh,
                       input bit ut, input bit um);
    bus.fetch_pc_i       = pc;
    bus.fetch_valid_i    = fv;
    bus.is_branch_i      = br;
    bus.upd_valid_i      = uv;
    bus.upd_pc_i         = upc;
    bus.upd_hist_i       = uh;
    bus.upd_taken_i      = ut;
    bus.upd_mispredict_i = um;
  endtask

  // One clock: drive, compare against model, advance model, cross the edge
  task automatic cycle(input logic [31:0] pc, input bit fv, input logic [1:0] br,
                       input bit uv, input logic [31:0] upc, input logic [4:0] uh,
                       input bit ut, input bit um);
    logic [1:0] exp_pt;
    logic [9:0] exp_ph;
    int ghr_after;
    drive(pc, fv, br, uv, upc, uh, ut, um);
    #1;
    model_predict(pc, br, exp_pt, exp_ph, ghr_after);
    obs_pt = bus.pred_taken_o;
    obs_ph = bus.pred_hist_o;
    check("pred_taken", 64'(obs_pt), 64'(exp_pt));
    check("pred_hist", 64'(obs_ph), 64'(exp_ph));
`ifdef BP_PERF_COUNTERS_EN
    check("perf_branches", 64'(bus.perf_branches_o), 64'(m_br));
    check("perf_mispredicts", 64'(bus.perf_mispredicts_o), 64'(m_mis));
`endif
    if (uv) begin
      int idx;
      idx = int'(((upc >> 2) ^ 32'(uh)) % 32'(ENTRIES));
      if (ut) m_pht[idx] = (m_pht[idx] < 3) ? m_pht[idx] + 1 : 3;
      else    m_pht[idx] = (m_pht[idx] > 0) ? m_pht[idx] - 1 : 0;
      m_br++;
      if (um) m_mis++;
    end
    if (uv && um)  m_ghr = ((int'(uh) * 2) + int'(ut)) % 32;
    else if (fv)   m_ghr = ghr_after;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(32'h0, 0, 2'b00, 0, 32'h0, 5'h0, 0, 0);
  endtask

  task automatic train(input logic [31:0] upc, input logic [4:0] uh, input bit ut);
    cycle(32'h0, 0, 2'b00, 1, upc, uh, ut, 0);
  endtask

  task automatic async_reset_check(input string tag);
    reset = 1'b0;
    #2;
    model_reset();
    drive(32'h40, 1, 2'b11, 0, 32'h0, 5'h0, 0, 0);
    #1;
    check({tag, "_pt"}, 64'(bus.pred_taken_o), 64'h0);
    check({tag, "_ph"}, 64'(bus.pred_hist_o), 64'h0);
`ifdef BP_PERF_COUNTERS_EN
    check({tag, "_perf_br"}, 64'(bus.perf_branches_o), 64'h0);
    check({tag, "_perf_mis"}, 64'(bus.perf_mispredicts_o), 64'h0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    drive(32'h40, 0, 2'b11, 0, 32'h0, 5'h0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_pt", 64'(bus.pred_taken_o), 64'h0);
    check("reset_ph", 64'(bus.pred_hist_o), 64'h0);
    reset = 1'b1;

    // Fresh table predicts not-taken; GHR shifts in zeros
    cycle(32'h40, 1, 2'b11, 0, 32'h0, 5'h0, 0, 0);
    check("t1_pt", 64'(obs_pt), 64'h0);
    check("t1_ph", 64'(obs_ph), 64'h0);
    idle();
    check("t1_ghr", 64'(obs_ph[4:0]), 64'h0);

    // Two taken updates push entry to strongly taken
    train(32'h40, 5'h0, 1);
    train(32'h40, 5'h0, 1);
    cycle(32'h40, 1, 2'b01, 0, 32'h0, 5'h0, 0, 0);
    check("t2_pt0", 64'(obs_pt[0]), 64'h1);
    idle();
    check("t2_ghr", 64'(obs_ph[4:0]), 64'h1);

    // Recover GHR to 0 using an unrelated entry, then saturation / decrement
    cycle(32'h0, 0, 2'b00, 1, 32'h80, 5'h0, 0, 1);
    repeat (3) train(32'h40, 5'h0, 1);
    train(32'h40, 5'h0, 0);
    cycle(32'h40, 0, 2'b01, 0, 32'h0, 5'h0, 0, 0);
    check("t3_weak_taken", 64'(obs_pt[0]), 64'h1);
    train(32'h40, 5'h0, 0);
    cycle(32'h40, 0, 2'b01, 0, 32'h0, 5'h0, 0, 0);
    check("t3_weak_nt", 64'(obs_pt[0]), 64'h0);

    // Lane 1 hashes to the same strong entry but is squashed by lane 0
    train(32'h40, 5'h0, 1);
    train(32'h40, 5'h0, 1);
    cycle(32'h40, 1, 2'b11, 0, 32'h0, 5'h0, 0, 0);
    check("t4_squash", 64'(obs_pt), 64'h1);
    idle();
    check("t4_ghr", 64'(obs_ph[4:0]), 64'h1);

    // Recovery beats a same-cycle fetch shift
    cycle(32'h0, 0, 2'b00, 1, 32'h80, 5'b00011, 1, 1);
    idle();
    check("t5_ghr_pre", 64'(obs_ph[4:0]), 64'h07);
    cycle(32'h40, 1, 2'b11, 1, 32'h80, 5'b10110, 0, 1);
    idle();
    check("t5_ghr_recover", 64'(obs_ph[4:0]), 64'h0C);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] pc, upc;
      logic [1:0]  br;
      logic [4:0]  uh;
      bit fv, uv, ut, um;
      pc  = 32'($urandom_range(0, 127)) << 2;
      upc = 32'($urandom_range(0, 127)) << 2;
      br  = 2'($urandom_range(0, 3));
      uh  = 5'($urandom_range(0, 31));
      fv  = ($urandom_range(0, 9) < 7);
      uv  = ($urandom_range(0, 1) == 1);
      ut  = ($urandom_range(0, 2) != 0);
      um  = ($urandom_range(0, 3) == 0);
      cycle(pc, fv, br, uv, upc, uh, ut, um);
    end

    // Async reset mid-run, then confirm table is back to weak not-taken
    async_reset_check("midrun_reset");
    for (int n = 0; n < 16; n++) begin
      cycle(32'(n) << 2, 0, 2'b11, 0, 32'h0, 5'h0, 0, 0);
      check("post_reset_nt", 64'(obs_pt), 64'h0);
    end

`ifdef BP_PERF_COUNTERS_EN
    for (int n = 0; n < 10; n++) begin
      cycle(32'h0, 0, 2'b00, 1, 32'(n) << 2, 5'h0, 1, (n < 3));
    end
    #1;
    check("perf_br_10", 64'(bus.perf_branches_o), 64'd10);
    check("perf_mis_3", 64'(bus.perf_mispredicts_o), 64'd3);
    async_reset_check("perf_reset");
    idle();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
